// File: rtl/tap_sdram_fetcher_if.sv
// SDRAM port2 toggle-handshake bundle between the TAP fetcher (master) and the SDRAM controller (slave).
interface tap_sdram_fetcher_if;
  logic        sd_req;
  logic        sd_ack;
  logic [22:0] sd_a;
  logic [1:0]  sd_ds;
  logic        sd_we;
  logic [15:0] sd_d;
  logic [15:0] sd_q;

  modport master (output sd_req, sd_a, sd_ds, sd_we, sd_d, input sd_ack, sd_q);
  modport slave  (input sd_req, sd_a, sd_ds, sd_we, sd_d, output sd_ack, sd_q);
endinterface

// File: rtl/tap_sdram_fetcher.sv
// TAP download writer and playback byte server over SDRAM port2, with a 2-word
// LRU line buffer that prefetches the next word so sequential playback never stalls.
module tap_sdram_fetcher #(
  parameter int          AW     = 24,
  parameter logic [22:0] BASE_W = 23'h0
) (
  input  logic                clk_72,
  input  logic                reset,
  input  logic                dl_active,
  input  logic                ioctl_wr,
  input  logic [AW-1:0]       ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic                byte_req,
  input  logic [AW-1:0]       byte_addr,
  output logic                byte_ack,
  output logic [7:0]          byte_out,
  output logic [AW-1:0]       tap_last,
  output logic                eot,
  output logic                overrun,
  tap_sdram_fetcher_if.master sd
);
  localparam int WW = AW - 1;

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, PF_WAIT} state_t;

  state_t             state_q, state_d;
  logic               byte_ack_q, byte_ack_d;
  logic [7:0]         byte_out_q, byte_out_d;
  logic [AW-1:0]      tap_last_q, tap_last_d;
  logic               eot_q, eot_d;
  logic               overrun_q, overrun_d;
  logic               sd_req_q, sd_req_d;
  logic [22:0]        sd_a_q, sd_a_d;
  logic [1:0]         sd_ds_q, sd_ds_d;
  logic               sd_we_q, sd_we_d;
  logic [15:0]        sd_d_q, sd_d_d;
  logic [1:0]         vld_q, vld_d;
  logic [1:0][WW-1:0] wa_q, wa_d;
  logic [1:0][15:0]   dat_q, dat_d;
  logic               newest_q, newest_d;
  logic               hold_vld_q, hold_vld_d;
  logic [AW-1:0]      hold_addr_q, hold_addr_d;
  logic [7:0]         hold_dat_q, hold_dat_d;
  logic [WW-1:0]      rd_wa_q, rd_wa_d;
  logic               kill_q, kill_d;
  logic               dl_q, dl_d;

  logic               dl_rise_s, pend_raw_s, pend_s, past_end_s, done_s;
  logic               hit0_s, hit1_s, lru_s, pf_ok_s;
  logic [WW-1:0]      req_wa_s, nxt_wa_s;
  logic               wr_go_s, rd_go_s;
  logic [AW-1:0]      wr_addr_s;
  logic [7:0]         wr_dat_s;
  logic [WW-1:0]      rd_word_s;

  function automatic logic [22:0] sd_word(input logic [WW-1:0] w);
    return BASE_W + 23'(w);
  endfunction

  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  assign dl_rise_s  = dl_active & ~dl_q;
  assign pend_raw_s = byte_req ^ byte_ack_q;
  assign pend_s     = pend_raw_s & ~dl_active;
  assign req_wa_s   = byte_addr[AW-1:1];
  assign past_end_s = byte_addr > tap_last_q;
  assign hit0_s     = vld_q[0] & (wa_q[0] == req_wa_s);
  assign hit1_s     = vld_q[1] & (wa_q[1] == req_wa_s);
  assign done_s     = (sd.sd_ack == sd_req_q);
  assign lru_s      = ~newest_q;
  assign nxt_wa_s   = wa_q[newest_q] + WW'(1);
  // The last word of the address space has no successor, so it never prefetches.
  assign pf_ok_s    = vld_q[newest_q] & (wa_q[newest_q] != {WW{1'b1}})
                    & ~(vld_q[0] & (wa_q[0] == nxt_wa_s))
                    & ~(vld_q[1] & (wa_q[1] == nxt_wa_s))
                    & ({nxt_wa_s, 1'b0} <= tap_last_q);

  // Next-state logic: request issue, buffer fill, byte service and download bookkeeping.
  always_comb begin
    state_d     = state_q;
    byte_ack_d  = byte_ack_q;
    byte_out_d  = byte_out_q;
    tap_last_d  = tap_last_q;
    eot_d       = pend_s & past_end_s;
    overrun_d   = overrun_q;
    sd_req_d    = sd_req_q;
    sd_a_d      = sd_a_q;
    sd_ds_d     = sd_ds_q;
    sd_we_d     = sd_we_q;
    sd_d_d      = sd_d_q;
    vld_d       = vld_q;
    wa_d        = wa_q;
    dat_d       = dat_q;
    newest_d    = newest_q;
    hold_vld_d  = hold_vld_q;
    hold_addr_d = hold_addr_q;
    hold_dat_d  = hold_dat_q;
    rd_wa_d     = rd_wa_q;
    kill_d      = kill_q;
    dl_d        = dl_active;
    wr_go_s     = 1'b0;
    wr_addr_s   = ioctl_addr;
    wr_dat_s    = ioctl_dout;
    rd_go_s     = 1'b0;
    rd_word_s   = req_wa_s;

    if (pend_s && !past_end_s && (hit0_s || hit1_s)) begin
      byte_ack_d = ~byte_ack_q;
      byte_out_d = pick_byte(dat_q[hit1_s], byte_addr[0]);
      newest_d   = hit1_s;
    end else begin
      byte_ack_d = byte_ack_q;
    end

    case (state_q)
      IDLE: begin
        if (hold_vld_q) begin
          wr_go_s    = 1'b1;
          wr_addr_s  = hold_addr_q;
          wr_dat_s   = hold_dat_q;
          hold_vld_d = 1'b0;
        end else if (ioctl_wr) begin
          wr_go_s = 1'b1;
        end else if (pend_s && !past_end_s && !hit0_s && !hit1_s) begin
          rd_go_s   = 1'b1;
          rd_word_s = req_wa_s;
          state_d   = RD_WAIT;
        end else if (!pend_raw_s && !dl_active && pf_ok_s) begin
          rd_go_s   = 1'b1;
          rd_word_s = nxt_wa_s;
          state_d   = PF_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (done_s) state_d = IDLE;
        else        state_d = WR_WAIT;
      end
      RD_WAIT, PF_WAIT: begin
        if (done_s) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (!kill_q) begin
            vld_d[lru_s] = 1'b1;
            wa_d[lru_s]  = rd_wa_q;
            dat_d[lru_s] = sd.sd_q;
            newest_d     = lru_s;
            if (state_q == RD_WAIT && pend_s && req_wa_s == rd_wa_q) begin
              byte_ack_d = ~byte_ack_q;
              byte_out_d = pick_byte(sd.sd_q, byte_addr[0]);
            end else begin
              byte_out_d = byte_out_q;
            end
          end else begin
            vld_d = vld_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_go_s) begin
      sd_a_d     = sd_word(wr_addr_s[AW-1:1]);
      sd_ds_d    = wr_addr_s[0] ? 2'b10 : 2'b01;
      sd_we_d    = 1'b1;
      sd_d_d     = {wr_dat_s, wr_dat_s};
      sd_req_d   = ~sd_req_q;
      tap_last_d = wr_addr_s;
      state_d    = WR_WAIT;
    end else if (rd_go_s) begin
      sd_a_d   = sd_word(rd_word_s);
      sd_ds_d  = 2'b11;
      sd_we_d  = 1'b0;
      sd_req_d = ~sd_req_q;
      rd_wa_d  = rd_word_s;
    end else begin
      sd_req_d = sd_req_q;
    end

    // A read still in flight when a download starts must not land in the fresh buffer.
    if (dl_rise_s) begin
      vld_d      = 2'b00;
      overrun_d  = 1'b0;
      tap_last_d = wr_go_s ? wr_addr_s : {AW{1'b0}};
      kill_d     = (state_d == RD_WAIT) || (state_d == PF_WAIT);
    end else begin
      kill_d = kill_d;
    end

    if (ioctl_wr && (state_q != IDLE || hold_vld_q)) begin
      if (hold_vld_q && state_q != IDLE) begin
        overrun_d = 1'b1;
      end else begin
        hold_vld_d  = 1'b1;
        hold_addr_d = ioctl_addr;
        hold_dat_d  = ioctl_dout;
      end
    end else begin
      hold_dat_d = hold_dat_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_72 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_ack_q  <= 1'b0;
      byte_out_q  <= 8'h00;
      tap_last_q  <= {AW{1'b0}};
      eot_q       <= 1'b0;
      overrun_q   <= 1'b0;
      sd_req_q    <= 1'b0;
      sd_a_q      <= 23'h0;
      sd_ds_q     <= 2'b00;
      sd_we_q     <= 1'b0;
      sd_d_q      <= 16'h0000;
      vld_q       <= 2'b00;
      wa_q        <= '{default: {WW{1'b0}}};
      dat_q       <= '{default: 16'h0000};
      newest_q    <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_addr_q <= {AW{1'b0}};
      hold_dat_q  <= 8'h00;
      rd_wa_q     <= {WW{1'b0}};
      kill_q      <= 1'b0;
      dl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_ack_q  <= byte_ack_d;
      byte_out_q  <= byte_out_d;
      tap_last_q  <= tap_last_d;
      eot_q       <= eot_d;
      overrun_q   <= overrun_d;
      sd_req_q    <= sd_req_d;
      sd_a_q      <= sd_a_d;
      sd_ds_q     <= sd_ds_d;
      sd_we_q     <= sd_we_d;
      sd_d_q      <= sd_d_d;
      vld_q       <= vld_d;
      wa_q        <= wa_d;
      dat_q       <= dat_d;
      newest_q    <= newest_d;
      hold_vld_q  <= hold_vld_d;
      hold_addr_q <= hold_addr_d;
      hold_dat_q  <= hold_dat_d;
      rd_wa_q     <= rd_wa_d;
      kill_q      <= kill_d;
      dl_q        <= dl_d;
    end
  end

  assign byte_ack  = byte_ack_q;
  assign byte_out  = byte_out_q;
  assign tap_last  = tap_last_q;
  assign eot       = eot_q;
  assign overrun   = overrun_q;
  assign sd.sd_req = sd_req_q;
  assign sd.sd_a   = sd_a_q;
  assign sd.sd_ds  = sd_ds_q;
  assign sd.sd_we  = sd_we_q;
  assign sd.sd_d   = sd_d_q;
endmodule

// File: tb/tb_tap_sdram_fetcher.sv
// Scoreboard bench for tap_sdram_fetcher: an SDRAM port2 model with fixed ack latency,
// expected writes and expected player bytes queued at stimulus time and checked on output.
module tb_tap_sdram_fetcher;
  localparam int AW     = 24;
  localparam int SD_LAT = 8;

  logic          clk_72 = 1'b0;
  logic          reset;
  logic          dl_active, ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          byte_req;
  logic [AW-1:0] byte_addr;
  logic          byte_ack;
  logic [7:0]    byte_out;
  logic [AW-1:0] tap_last;
  logic          eot, overrun;

  tap_sdram_fetcher_if sd_if ();

  tap_sdram_fetcher #(.AW(AW), .BASE_W(23'h0)) dut (
    .clk_72(clk_72), .reset(reset), .dl_active(dl_active), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .byte_req(byte_req),
    .byte_addr(byte_addr), .byte_ack(byte_ack), .byte_out(byte_out),
    .tap_last(tap_last), .eot(eot), .overrun(overrun), .sd(sd_if)
  );

  always #5 clk_72 = ~clk_72;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];

  // SDRAM port2 model
  logic [15:0] mem [0:63];
  logic        seen_req, busy, cur_we;
  logic [22:0] cur_a, last_rd_a;
  logic [1:0]  cur_ds;
  logic [15:0] cur_d;
  int          cnt, n_rd, n_sd;
  wr_t         exp_wr;

  always @(posedge clk_72 or posedge reset) begin
    if (reset) begin
      sd_if.sd_ack <= 1'b0;
      sd_if.sd_q   <= 16'h0000;
      seen_req = 1'b0;
      busy     = 1'b0;
      cnt      = 0;
    end else if (busy) begin
      if (sd_if.sd_req != seen_req) check("sd_one_outstanding", 32'(sd_if.sd_req), 32'(seen_req));
      if (cnt > 1) begin
        cnt--;
      end else begin
        busy = 1'b0;
        if (cur_we) begin
          if (cur_ds[0]) mem[cur_a[5:0]][7:0]  = cur_d[7:0];
          if (cur_ds[1]) mem[cur_a[5:0]][15:8] = cur_d[15:8];
        end else begin
          sd_if.sd_q <= mem[cur_a[5:0]];
        end
        sd_if.sd_ack <= seen_req;
      end
    end else if (sd_if.sd_req != seen_req) begin
      seen_req = sd_if.sd_req;
      busy     = 1'b1;
      cnt      = SD_LAT;
      cur_a    = sd_if.sd_a;
      cur_ds   = sd_if.sd_ds;
      cur_we   = sd_if.sd_we;
      cur_d    = sd_if.sd_d;
      n_sd++;
      if (cur_we) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 32'(wr_q.size()), 32'd1);
        end else begin
          exp_wr = wr_q.pop_front();
          check("wr_a", 32'(cur_a), 32'(exp_wr.a));
          check("wr_ds", 32'(cur_ds), 32'(exp_wr.ds));
          check("wr_d", 32'(cur_d), 32'(exp_wr.d));
        end
      end else begin
        n_rd++;
        last_rd_a = cur_a;
        check("rd_ds", 32'(cur_ds), 32'h3);
      end
    end
  end

  // Player-side monitor: every byte_ack toggle pops one expected byte.
  logic       ack_seen;
  logic [7:0] exp_byte;
  always @(negedge clk_72) begin
    if (reset) begin
      ack_seen = 1'b0;
    end else if (byte_ack != ack_seen) begin
      ack_seen = byte_ack;
      if (rd_q.size() == 0) begin
        check("ack_unexpected", 32'(rd_q.size()), 32'd1);
      end else begin
        exp_byte = rd_q.pop_front();
        check("byte_out", 32'(byte_out), 32'(exp_byte));
      end
    end
  end

  int n_req_made = 0;

  task automatic dl_write(input logic [AW-1:0] a, input logic [7:0] d);
    wr_t e;
    e.a  = 23'(a[AW-1:1]);
    e.ds = a[0] ? 2'b10 : 2'b01;
    e.d  = {d, d};
    wr_q.push_back(e);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_72);
    ioctl_wr = 1'b0;
    repeat (14) @(negedge clk_72);
  endtask

  task automatic player_req(input logic [AW-1:0] a, input logic [7:0] e);
    @(negedge clk_72);
    byte_addr = a;
    byte_req  = ~byte_req;
    rd_q.push_back(e);
    n_req_made++;
  endtask

  task automatic wait_ack(input int budget, output int cycles);
    logic start;
    start  = byte_ack;
    cycles = 0;
    while (cycles < budget && byte_ack == start) begin
      @(posedge clk_72);
      #1;
      cycles++;
    end
    check("ack_in_time", 32'(byte_ack != start), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int lat, rd_base, sd_base;
  wr_t e0, e1;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    n_rd = 0; n_sd = 0;
    reset = 1'b1; dl_active = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = 8'h00;
    byte_req = 1'b0; byte_addr = '0;
    repeat (4) @(negedge clk_72);
    check("rst_byte_ack", 32'(byte_ack), 32'd0);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_tap_last", 32'(tap_last), 32'd0);
    check("rst_eot", 32'(eot), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_sd_req", 32'(sd_if.sd_req), 32'd0);
    check("rst_sd_a", 32'(sd_if.sd_a), 32'd0);
    check("rst_sd_ds_we_d", {13'd0, sd_if.sd_ds, sd_if.sd_we, sd_if.sd_d}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_72);

    // Download 1: back-to-back strobes, the third one has nowhere to go.
    dl_active = 1'b1;
    @(negedge clk_72);
    e0.a = 23'h0; e0.ds = 2'b01; e0.d = 16'hA0A0; wr_q.push_back(e0);
    e1.a = 23'h0; e1.ds = 2'b10; e1.d = 16'hA1A1; wr_q.push_back(e1);
    ioctl_wr = 1'b1; ioctl_addr = 24'd0; ioctl_dout = 8'hA0;
    @(negedge clk_72); ioctl_addr = 24'd1; ioctl_dout = 8'hA1;
    @(negedge clk_72); ioctl_addr = 24'd2; ioctl_dout = 8'hA2;
    @(negedge clk_72); ioctl_wr = 1'b0;
    repeat (30) @(negedge clk_72);
    check("overrun_set", 32'(overrun), 32'd1);
    check("tap_last_dl1", 32'(tap_last), 32'd1);
    check("wr_q_drained_dl1", 32'(wr_q.size()), 32'd0);
    dl_active = 1'b0;
    repeat (3) @(negedge clk_72);

    // Download 2: 0x11,0x22,0x33 at 0..2.
    dl_active = 1'b1;
    repeat (2) @(negedge clk_72);
    check("overrun_cleared", 32'(overrun), 32'd0);
    check("tap_last_cleared", 32'(tap_last), 32'd0);
    dl_write(24'd0, 8'h11);
    dl_write(24'd1, 8'h22);
    dl_write(24'd2, 8'h33);
    check("tap_last_dl2", 32'(tap_last), 32'd2);
    check("wr_q_drained_dl2", 32'(wr_q.size()), 32'd0);
    dl_active = 1'b0;
    @(negedge clk_72);

    // Demand miss on word 0, then prefetch of word 1.
    rd_base = n_rd;
    player_req(24'd0, 8'h11);
    wait_ack(40, lat);
    check("miss_latency_window", 32'((lat >= 9) && (lat <= 13)), 32'd1);
    repeat (20) @(negedge clk_72);
    check("prefetch_reads", 32'(n_rd - rd_base), 32'd2);
    check("prefetch_addr", 32'(last_rd_a), 32'd1);

    // Hits: addr 1 from word 0, addr 2 from the prefetched word.
    sd_base = n_sd;
    player_req(24'd1, 8'h22);
    wait_ack(5, lat);
    check("hit_latency", 32'(lat), 32'd1);
    player_req(24'd2, 8'h33);
    wait_ack(5, lat);
    check("hit_latency_prefetched", 32'(lat), 32'd1);
    repeat (2) @(negedge clk_72);
    check("hits_no_sd_req", 32'(n_sd - sd_base), 32'd0);

    // Past the end of tape: stall with eot.
    sd_base = n_sd;
    player_req(24'd3, 8'h44);
    repeat (3) @(negedge clk_72);
    check("eot_set", 32'(eot), 32'd1);
    repeat (100) @(negedge clk_72);
    check("eot_no_ack", 32'(byte_ack), 32'((n_req_made - 1) % 2));
    check("eot_no_sd_req", 32'(n_sd - sd_base), 32'd0);
    check("eot_held", 32'(eot), 32'd1);

    // Download 3 extends the tape; the stalled request is then served.
    dl_active = 1'b1;
    repeat (2) @(negedge clk_72);
    check("eot_clear_in_dl", 32'(eot), 32'd0);
    dl_write(24'd0, 8'h11);
    dl_write(24'd1, 8'h22);
    dl_write(24'd2, 8'h33);
    dl_write(24'd3, 8'h44);
    check("tap_last_dl3", 32'(tap_last), 32'd3);
    dl_active = 1'b0;
    wait_ack(40, lat);
    @(negedge clk_72);
    check("eot_clear_served", 32'(eot), 32'd0);

    // Download start while a demand read is in flight.
    player_req(24'd0, 8'h11);
    repeat (3) @(negedge clk_72);
    dl_active = 1'b1;
    repeat (20) @(negedge clk_72);
    check("kill_no_ack", 32'(byte_ack), 32'((n_req_made - 1) % 2));
    check("kill_tap_last", 32'(tap_last), 32'd0);
    check("kill_read_done", 32'(busy), 32'd0);
    rd_base = n_rd;
    dl_active = 1'b0;
    wait_ack(40, lat);
    check("refetch_after_kill", 32'(n_rd - rd_base), 32'd1);
    repeat (4) @(negedge clk_72);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained_end", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
